regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the register file's single write port (RegWrite/A3/WD3) between two writeback requesters:
// req0 = ALU/data-processing result, req1 = multi-cycle unit (load/multiply).
// Round-robin arbitration with valid/ready handshakes and a registered write stage.
// Keeps a 16-entry pending-write scoreboard so issue logic can detect RAW hazards on read ports A1/A2.
// PARAMETERS
// W        32  datapath width, matches register file W
// RR_INIT  0   requester that wins the first tie after reset (0 or 1)
// PORTS
// clk         in   1   rising-edge clock, same as register file
// reset_n     in   1   asynchronous, active-low reset
// req0_valid  in   1   requester 0 has a write pending
// req0_ready  out  1   requester 0 write accepted this cycle
// req0_addr   in   4   requester 0 destination register
// req0_data   in   W   requester 0 write data
// req1_valid  in   1   requester 1 has a write pending
// req1_ready  out  1   requester 1 write accepted this cycle
// req1_addr   in   4   requester 1 destination register
// req1_data   in   W   requester 1 write data
// rsv_valid   in   1   issue stage reserves a destination for a multi-cycle op
// rsv_addr    in   4   register being reserved
// rsv_err     out  1   registered 1-cycle pulse: reservation of an already-busy register, ignored
// rd_addr1    in   4   register file A1, for hazard check
// rd_addr2    in   4   register file A2, for hazard check
// hazard1     out  1   combinational: busy[rd_addr1]
// hazard2     out  1   combinational: busy[rd_addr2]
// busy        out  16  scoreboard, bit n = write to Rn outstanding
// wb_we       out  1   drives register file RegWrite
// wb_addr     out  4   drives register file A3
// wb_data     out  W   drives register file WD3
// wb_trap     out  1   registered 1-cycle pulse: a write to R15 was dropped (PC_WRITE_TRAP_EN only)
// BEHAVIOUR
// - Reset: wb_we=0, wb_addr=0, wb_data=0, busy=0, rsv_err=0, wb_trap=0, priority pointer=RR_INIT.
// - Arbitration is combinational per cycle. One valid requester -> it is granted.
//   Both valid -> the requester named by the priority pointer is granted.
//   Neither valid -> no grant, and wb_we=0 on the next edge.
// - reqN_ready = grant to N. Handshake = valid & ready. A requester that loses holds valid/addr/data stable.
// - After a grant, the pointer moves to the other requester. With no grant, the pointer holds.
//   Two requesters that stay valid therefore alternate strictly: 0,1,0,1...
// - The write stage is registered. A handshake in cycle t gives wb_we=1 with wb_addr/wb_data in cycle t+1.
//   The register file captures the write at the end of t+1. Sustains 1 write per cycle.
// - Scoreboard:
//   - Set: rsv_valid & !busy[rsv_addr] sets busy[rsv_addr] at the next edge.
//   - Reject: rsv_valid & busy[rsv_addr] leaves busy unchanged and pulses rsv_err in the next cycle.
//   - Clear: wb_we clears busy[wb_addr] at the end of the wb_we cycle, the same edge the register file writes.
//   - Reserve and clear on the same register in the same cycle: the clear applies, then the reservation sets.
//     The bit stays 1 and rsv_err is not raised.
//   - A write to a register that is not busy is legal and leaves busy unchanged.
// - hazard1/2 are combinational from busy and rd_addr1/2. No forwarding is done.
// - An asynchronous reset during any operation clears everything immediately. In-flight writes are lost.
// CONFIGURATION
// PC_WRITE_TRAP_EN defined:
// - A handshake with addr=15 is accepted (ready=1, pointer advances).
// - The next cycle has wb_we=0, and wb_trap pulses for 1 cycle.
// - busy[15] is never set: rsv_addr=15 pulses rsv_err.
// PC_WRITE_TRAP_EN undefined:
// - addr=15 is forwarded like any other write. R15 is owned by the PC path, so the write has no effect.
// - wb_trap is tied to 0, and busy[15] follows the normal scoreboard rules.
// TESTING
// 1. Reset: hold reset_n=0 mid-stream -> all outputs 0 at once. Release -> first tie goes to RR_INIT.
// 2. Single requester: req0 {addr=3, data=0xDEADBEEF} in cycle t -> req0_ready=1 in t.
//    In t+1: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF.
// 3. Contention: req0 and req1 valid for 4 cycles, RR_INIT=0 -> grants 0,1,0,1.
//    Each loser holds its data, and the wb_* sequence matches the grant order.
// 4. Scoreboard: reserve R5 -> busy=0x0020 and hazard1=1 with rd_addr1=5.
//    Reserve R5 again -> rsv_err pulse. req1 write to R5 -> busy=0 at the end of the wb_we cycle.
// 5. Same-cycle clear+reserve of R7 -> busy[7] stays 1 and rsv_err=0.
// 6. R15: req0 addr=15 -> with PC_WRITE_TRAP_EN: wb_we=0, wb_trap=1.
//    Without it: wb_we=1, wb_addr=15, wb_trap=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port (RegWrite/A3/WD3) between two
// writeback requesters: req0 (ALU / data-processing result) and req1
// (multi-cycle unit: load / multiply). A round-robin arbiter picks a winner
// each cycle, and the winner's write goes through one register stage
// (wb_we/wb_addr/wb_data). A 16-bit pending-write scoreboard (busy) lets the
// issue stage spot RAW hazards on read ports A1/A2.
//
// Handshake: a requester holds reqN_valid/addr/data stable until it sees
// reqN_ready. reqN_ready is the combinational grant, and a transfer happens on
// the rising edge where valid & ready are both 1. The write then appears on
// wb_* in the following cycle.
//
// Optional build macro: PC_WRITE_TRAP_EN
//   defined   - writes to R15 are accepted but dropped, and wb_trap pulses for
//               one cycle. R15 can never be reserved (rsv_err pulses instead).
//   undefined - R15 is treated like any other register, and wb_trap is 0.
//
// Parameters
//   W        datapath width (matches register file)
//   RR_INIT  requester that wins the first tie after reset
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   req0_valid/ready/addr/data    requester 0 write channel
//   req1_valid/ready/addr/data    requester 1 write channel
//   rsv_valid, rsv_addr           destination reservation from issue
//   rsv_err                       1-cycle pulse: reservation of a busy register
//   rd_addr1, rd_addr2            register file read addresses A1/A2
//   hazard1, hazard2              busy[rd_addr1], busy[rd_addr2] (combinational)
//   busy                          scoreboard, bit n = write to Rn outstanding
//   wb_we, wb_addr, wb_data       register file RegWrite / A3 / WD3
//   wb_trap                       1-cycle pulse: an R15 write was dropped
module regfile_wb_arbiter #(
    parameter int W       = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_addr,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_addr,
    input  logic [W-1:0] req1_data,
    input  logic         rsv_valid,
    input  logic [3:0]   rsv_addr,
    output logic         rsv_err,
    input  logic [3:0]   rd_addr1,
    input  logic [3:0]   rd_addr2,
    output logic         hazard1,
    output logic         hazard2,
    output logic [15:0]  busy,
    output logic         wb_we,
    output logic [3:0]   wb_addr,
    output logic [W-1:0] wb_data,
    output logic         wb_trap
);

    logic         ptr_q, ptr_d;       // requester that wins a tie
    logic         wb_we_q, wb_we_d;
    logic [3:0]   wb_addr_q, wb_addr_d;
    logic [W-1:0] wb_data_q, wb_data_d;
    logic [15:0]  busy_q, busy_d;
    logic         rsv_err_q, rsv_err_d;

    logic         grant0, grant1;
    logic [3:0]   sel_addr;
    logic [W-1:0] sel_data;

`ifdef PC_WRITE_TRAP_EN
    logic         wb_trap_q, wb_trap_d;
`endif

    always_comb begin
        grant0 = req0_valid && (!req1_valid || (ptr_q == 1'b0));
        grant1 = req1_valid && (!req0_valid || (ptr_q == 1'b1));

        // Pointer moves to the other requester after a grant, holds otherwise.
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end

        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;

        // Address/data hold their last value when idle; only wb_we matters.
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
`ifdef PC_WRITE_TRAP_EN
        wb_trap_d = 1'b0;
        if (grant0 || grant1) begin
            if (sel_addr == 4'd15) begin
                wb_trap_d = 1'b1;
            end else begin
                wb_we_d   = 1'b1;
                wb_addr_d = sel_addr;
                wb_data_d = sel_data;
            end
        end
`else
        if (grant0 || grant1) begin
            wb_we_d   = 1'b1;
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
        end
`endif

        // Clear first, then reserve against the cleared view, so a
        // reservation landing on the register being written this cycle
        // succeeds instead of raising rsv_err.
        busy_d = busy_q;
        if (wb_we_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end

        rsv_err_d = 1'b0;
        if (rsv_valid) begin
`ifdef PC_WRITE_TRAP_EN
            if (rsv_addr == 4'd15) begin
                rsv_err_d = 1'b1;
            end else
`endif
            if (busy_d[rsv_addr]) begin
                rsv_err_d = 1'b1;
            end else begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= RR_INIT;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= '0;
            busy_q    <= 16'd0;
            rsv_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

`ifdef PC_WRITE_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_trap_q <= 1'b0;
        end else begin
            wb_trap_q <= wb_trap_d;
        end
    end
    assign wb_trap = wb_trap_q;
`else
    assign wb_trap = 1'b0;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wb_we      = wb_we_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign busy       = busy_q;
    assign rsv_err    = rsv_err_q;
    assign hazard1    = busy_q[rd_addr1];
    assign hazard2    = busy_q[rd_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: writes accepted by the arbiter are
// queued as {addr,data}; a negedge monitor pops and compares each wb_we cycle.
module tb_regfile_wb_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         req0_valid, req0_ready;
    logic [3:0]   req0_addr;
    logic [W-1:0] req0_data;
    logic         req1_valid, req1_ready;
    logic [3:0]   req1_addr;
    logic [W-1:0] req1_data;
    logic         rsv_valid;
    logic [3:0]   rsv_addr;
    logic         rsv_err;
    logic [3:0]   rd_addr1, rd_addr2;
    logic         hazard1, hazard2;
    logic [15:0]  busy;
    logic         wb_we;
    logic [3:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         wb_trap;

    int checks;
    int failures;
    logic [W+3:0] exp_q[$];

    regfile_wb_arbiter #(.W(W), .RR_INIT(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2), .busy(busy),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_trap(wb_trap)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write on the register file port must match the queue head.
    always @(negedge clk) begin
        if (reset_n && wb_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr%0d/0x%0h expected=no write", wb_addr, wb_data);
            end else begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(wb_addr), 64'(e[W+3:W]));
                check("wb_data", 64'(wb_data), 64'(e[W-1:0]));
            end
        end
    end

    // Drive one cycle of inputs, then at the negedge check the grants and
    // queue the write that the expected winner will produce.
    task automatic cyc(input bit v0, input logic [3:0] a0, input logic [W-1:0] d0,
                       input bit v1, input logic [3:0] a1, input logic [W-1:0] d1,
                       input bit rv, input logic [3:0] ra,
                       input bit eg0, input bit eg1, input bit push_wr);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsv_valid  = rv; rsv_addr  = ra;
        @(negedge clk);
        check("req0_ready", 64'(req0_ready), 64'(eg0));
        check("req1_ready", 64'(req1_ready), 64'(eg1));
        if (push_wr && eg0) exp_q.push_back({a0, d0});
        if (push_wr && eg1) exp_q.push_back({a1, d1});
    endtask

    task automatic idle();
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 0, 4'd0, 0, 0, 1);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        rsv_valid = 0; rsv_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsv_err", 64'(rsv_err), 64'd0);
        check("rst_wb_trap", 64'(wb_trap), 64'd0);
        nxt();
        reset_n = 1'b1;

        // Contention: first tie goes to requester 0, then strict alternation.
        cyc(1, 4'd1, 32'h1111_1111, 1, 4'd2, 32'h2222_2222, 0, 4'd0, 1, 0, 1); nxt();
        cyc(1, 4'd4, 32'h4444_4444, 1, 4'd2, 32'h2222_2222, 0, 4'd0, 0, 1, 1); nxt();
        cyc(1, 4'd4, 32'h4444_4444, 1, 4'd6, 32'h6666_6666, 0, 4'd0, 1, 0, 1); nxt();
        cyc(1, 4'd8, 32'h8888_8888, 1, 4'd6, 32'h6666_6666, 0, 4'd0, 0, 1, 1); nxt();
        idle(); nxt();
        idle();
        check("idle_wb_we", 64'(wb_we), 64'd0);
        nxt();

        // Lone requester wins regardless of the pointer (pointer now 0).
        cyc(0, 4'd0, '0, 1, 4'd9, 32'h0000_0909, 0, 4'd0, 0, 1, 1); nxt();
        // Single write to a non-busy register.
        cyc(1, 4'd3, 32'hDEAD_BEEF, 0, 4'd0, '0, 0, 4'd0, 1, 0, 1); nxt();
        idle();
        check("nonbusy_write_busy", 64'(busy), 64'd0);
        nxt();
        // Pointer is at 1 after the req0 grant: tie goes to req1.
        cyc(1, 4'd10, 32'hA0A0_A0A0, 1, 4'd11, 32'hB0B0_B0B0, 0, 4'd0, 0, 1, 1); nxt();
        cyc(1, 4'd10, 32'hA0A0_A0A0, 0, 4'd0, '0, 0, 4'd0, 1, 0, 1); nxt();
        idle(); nxt();

        // Scoreboard: reserve R5, re-reserve (error), clear via write.
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd5, 0, 0, 1);
        check("rsv_first_err", 64'(rsv_err), 64'd0);
        nxt();
        rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd5, 0, 0, 1);
        check("busy_r5", 64'(busy), 64'h0020);
        check("hazard1_r5", 64'(hazard1), 64'd1);
        check("hazard2_r6", 64'(hazard2), 64'd0);
        check("rsv_err_none", 64'(rsv_err), 64'd0);
        nxt();
        cyc(0, 4'd0, '0, 1, 4'd5, 32'h55AA_55AA, 0, 4'd0, 0, 1, 1);
        check("rsv_err_pulse", 64'(rsv_err), 64'd1);
        check("busy_after_rej", 64'(busy), 64'h0020);
        nxt();
        idle();
        check("rsv_err_drop", 64'(rsv_err), 64'd0);
        check("busy_wb_cycle", 64'(busy), 64'h0020);
        nxt();
        idle();
        check("busy_cleared", 64'(busy), 64'd0);
        check("hazard1_cleared", 64'(hazard1), 64'd0);
        nxt();

        // Same-cycle clear and reserve of R7.
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd7, 0, 0, 1); nxt();
        cyc(1, 4'd7, 32'h0000_0077, 0, 4'd0, '0, 0, 4'd0, 1, 0, 1);
        check("busy_r7", 64'(busy), 64'h0080);
        nxt();
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd7, 0, 0, 1);
        check("busy_r7_wb", 64'(busy), 64'h0080);
        nxt();
        idle();
        check("busy_r7_kept", 64'(busy), 64'h0080);
        check("rsv_err_r7", 64'(rsv_err), 64'd0);
        nxt();
        cyc(1, 4'd7, 32'h0000_7070, 0, 4'd0, '0, 0, 4'd0, 1, 0, 1); nxt();
        idle(); nxt();
        idle();
        check("busy_r7_clear", 64'(busy), 64'd0);
        nxt();

        // R15 write.
`ifdef PC_WRITE_TRAP_EN
        cyc(1, 4'd15, 32'hF00D_F00D, 0, 4'd0, '0, 0, 4'd0, 1, 0, 0); nxt();
        cyc(0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd15, 0, 0, 1);
        check("r15_wb_we", 64'(wb_we), 64'd0);
        check("r15_trap", 64'(wb_trap), 64'd1);
        nxt();
        idle();
        check("r15_trap_drop", 64'(wb_trap), 64'd0);
        check("r15_rsv_err", 64'(rsv_err), 64'd1);
        check("r15_busy", 64'(busy), 64'd0);
        nxt();
`else
        cyc(1, 4'd15, 32'hF00D_F00D, 0, 4'd0, '0, 0, 4'd0, 1, 0, 1); nxt();
        idle();
        check("r15_wb_we", 64'(wb_we), 64'd1);
        check("r15_trap", 64'(wb_trap), 64'd0);
        nxt();
`endif
        idle(); nxt();

        // Mid-stream reset: a write in flight plus a reservation are lost.
        cyc(1, 4'd2, 32'h1234_5678, 0, 4'd0, '0, 1, 4'd2, 1, 0, 0);
        nxt();
        req0_valid = 0; rsv_valid = 0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_wb_we", 64'(wb_we), 64'd0);
        check("mid_rst_wb_addr", 64'(wb_addr), 64'd0);
        check("mid_rst_wb_data", 64'(wb_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rsv_err", 64'(rsv_err), 64'd0);
        nxt();
        reset_n = 1'b1;
        // Pointer was at 1 before reset; after reset the tie goes to RR_INIT=0.
        cyc(1, 4'd12, 32'hC0C0_C0C0, 1, 4'd13, 32'hD0D0_D0D0, 0, 4'd0, 1, 0, 1); nxt();
        cyc(0, 4'd0, '0, 1, 4'd13, 32'hD0D0_D0D0, 0, 4'd0, 0, 1, 1); nxt();
        idle(); nxt();
        idle(); nxt();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
